// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: shares one can_tx frame engine between N_MB mailboxes.
// A mailbox is picked by fixed priority (index 0 highest). The scheduler
// waits for the interframe gap on the bus, holds the engine's start level
// and retries failed attempts. It reports one done or error pulse per
// completed request.
//
// Mailbox handshake: mb_req_i[k] is a level request. The scheduler answers
// with exactly one single-cycle pulse, either mb_done_o[k] or mb_err_o[k].
// After a done pulse, or an error raised because the retries ran out, mailbox
// k is masked for one IDLE cycle. This gives the requester one cycle to drop
// mb_req_i[k] before it can be selected again. If the request is dropped
// early, the current mailbox ends with an error pulse and no further attempt
// is made. mb_data_i and mb_addr_i are sampled only when a mailbox is
// selected.
module can_tx_scheduler #(
  parameter int N_MB      = 4,
  parameter int IFS_BITS  = 11,
  parameter int RETRY_MAX = 8,
  parameter int START_TO  = 16,
  localparam int MB_W     = (N_MB > 1) ? $clog2(N_MB) : 1
) (
  input  logic                 clk_can,
  input  logic                 rst_i,
  input  logic [N_MB-1:0]      mb_req_i,
  input  logic [64*N_MB-1:0]   mb_data_i,
  input  logic [6*N_MB-1:0]    mb_addr_i,
  output logic [N_MB-1:0]      mb_done_o,
  output logic [N_MB-1:0]      mb_err_o,
  input  logic                 rx_i,
  output logic                 tx_start_o,
  output logic [63:0]          tx_data_o,
  output logic [5:0]           tx_remote_addr_o,
  input  logic                 tx_busy_i,
  input  logic                 frame_sent_i,
  input  logic                 ack_i,
  input  logic                 lost_arb_i,
  output logic                 busy_o,
  output logic [MB_W-1:0]      cur_mb_o,
  output logic [7:0]           lost_arb_cnt_o
);

  localparam int GAP_W = $clog2(IFS_BITS + 1);
  localparam int ATT_W = $clog2(RETRY_MAX + 1);
  localparam int TO_W  = $clog2(START_TO + 1);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFS_BITS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TO - 1);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(RETRY_MAX);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GAP       = 2'd1;
  localparam logic [1:0] ST_START     = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [ATT_W-1:0] attempt_q, attempt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [N_MB-1:0]  mask_q, mask_d;
  logic [N_MB-1:0]  done_q, done_d;
  logic [N_MB-1:0]  err_q, err_d;
  logic             tx_start_q, tx_start_d;
  logic [63:0]      tx_data_q, tx_data_d;
  logic [5:0]       tx_addr_q, tx_addr_d;
  logic [MB_W-1:0]  cur_mb_q, cur_mb_d;
  logic [7:0]       lost_cnt_q, lost_cnt_d;

  logic [N_MB-1:0]  avail;
  logic             sel_found;
  logic [MB_W-1:0]  sel_idx;
  logic [63:0]      sel_data;
  logic [5:0]       sel_addr;
  logic             req_cur;
  logic             fail_c;

  assign avail   = mb_req_i & ~mask_q;
  assign req_cur = mb_req_i[cur_mb_q];

  // Fixed-priority pick: scan from the top so the lowest set index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    sel_addr  = '0;
    for (int i = N_MB - 1; i >= 0; i--) begin
      if (avail[i]) begin
        sel_found = 1'b1;
        sel_idx   = MB_W'(i);
        sel_data  = mb_data_i[64*i +: 64];
        sel_addr  = mb_addr_i[6*i +: 6];
      end
    end
  end

  // Next-state logic. A failed attempt is flagged in the per-state branches
  // and resolved in one place afterwards: retry, give up, or abort.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    attempt_d  = attempt_q;
    to_cnt_d   = to_cnt_q;
    mask_d     = mask_q;
    done_d     = '0;
    err_d      = '0;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    tx_addr_d  = tx_addr_q;
    cur_mb_d   = cur_mb_q;
    lost_cnt_d = lost_cnt_q;
    fail_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mask_d = '0;
        if (sel_found) begin
          tx_data_d = sel_data;
          tx_addr_d = sel_addr;
          cur_mb_d  = sel_idx;
          attempt_d = '0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end

      ST_GAP: begin
        if (!req_cur) begin
          // Requester withdrew before the frame started.
          err_d[cur_mb_q] = 1'b1;
          gap_cnt_d       = '0;
          state_d         = ST_IDLE;
        end else if (!rx_i) begin
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d  = '0;
          to_cnt_d   = '0;
          tx_start_d = 1'b1;
          state_d    = ST_START;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      ST_START: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          fail_c = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        // Lost arbitration takes precedence over a same-cycle frame_sent.
        if (lost_arb_i) begin
          fail_c = 1'b1;
          if (lost_cnt_q != 8'hFF) begin
            lost_cnt_d = lost_cnt_q + 8'd1;
          end
        end else if (frame_sent_i) begin
          if (ack_i) begin
            tx_start_d       = 1'b0;
            done_d[cur_mb_q] = 1'b1;
            mask_d[cur_mb_q] = 1'b1;
            state_d          = ST_IDLE;
          end else begin
            fail_c = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail_c) begin
      tx_start_d = 1'b0;
      attempt_d  = attempt_q + ATT_W'(1);
      if (attempt_d == ATT_MAX) begin
        err_d[cur_mb_q]  = 1'b1;
        mask_d[cur_mb_q] = 1'b1;
        state_d          = ST_IDLE;
      end else if (req_cur) begin
        // Retry the same mailbox with the latched frame; no re-arbitration.
        gap_cnt_d = '0;
        state_d   = ST_GAP;
      end else begin
        err_d[cur_mb_q] = 1'b1;
        state_d         = ST_IDLE;
      end
    end
  end

  // State and output registers; reset clears everything, including tx_start.
  always_ff @(posedge clk_can or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      attempt_q  <= '0;
      to_cnt_q   <= '0;
      mask_q     <= '0;
      done_q     <= '0;
      err_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_addr_q  <= '0;
      cur_mb_q   <= '0;
      lost_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      attempt_q  <= attempt_d;
      to_cnt_q   <= to_cnt_d;
      mask_q     <= mask_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tx_addr_q  <= tx_addr_d;
      cur_mb_q   <= cur_mb_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign mb_done_o        = done_q;
  assign mb_err_o         = err_q;
  assign tx_start_o       = tx_start_q;
  assign tx_data_o        = tx_data_q;
  assign tx_remote_addr_o = tx_addr_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign cur_mb_o         = cur_mb_q;
  assign lost_arb_cnt_o   = lost_cnt_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Testbench for can_tx_scheduler. It includes a reactive can_tx model, a
// result scoreboard and a tx_start timing monitor.
module tb_can_tx_scheduler;

  localparam int N_MB      = 4;
  localparam int IFS_BITS  = 11;
  localparam int RETRY_MAX = 8;
  localparam int START_TO  = 16;
  localparam int W         = 73;  // {err, idx[1:0], addr[5:0], data[63:0]}

  localparam int R_ACK    = 0;
  localparam int R_NACK   = 1;
  localparam int R_LOST   = 2;
  localparam int R_NOBUSY = 3;
  localparam int R_HOLD   = 4;

  logic                clk_can;
  logic                rst_i;
  logic [N_MB-1:0]     mb_req_i;
  logic [64*N_MB-1:0]  mb_data_i;
  logic [6*N_MB-1:0]   mb_addr_i;
  logic [N_MB-1:0]     mb_done_o;
  logic [N_MB-1:0]     mb_err_o;
  logic                rx_i;
  logic                tx_start_o;
  logic [63:0]         tx_data_o;
  logic [5:0]          tx_remote_addr_o;
  logic                tx_busy_i;
  logic                frame_sent_i;
  logic                ack_i;
  logic                lost_arb_i;
  logic                busy_o;
  logic [1:0]          cur_mb_o;
  logic [7:0]          lost_arb_cnt_o;

  logic [W-1:0] exp_q[$];
  int           resp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rises  = 0;
  int n_pulses = 0;
  int n_starts = 0;
  int rise_cyc = 0;
  int pulse_cyc = 0;

  can_tx_scheduler #(
    .N_MB(N_MB), .IFS_BITS(IFS_BITS), .RETRY_MAX(RETRY_MAX), .START_TO(START_TO)
  ) dut (
    .clk_can(clk_can), .rst_i(rst_i),
    .mb_req_i(mb_req_i), .mb_data_i(mb_data_i), .mb_addr_i(mb_addr_i),
    .mb_done_o(mb_done_o), .mb_err_o(mb_err_o), .rx_i(rx_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_remote_addr_o(tx_remote_addr_o), .tx_busy_i(tx_busy_i),
    .frame_sent_i(frame_sent_i), .ack_i(ack_i), .lost_arb_i(lost_arb_i),
    .busy_o(busy_o), .cur_mb_o(cur_mb_o), .lost_arb_cnt_o(lost_arb_cnt_o)
  );

  // Clock and cycle counter
  initial begin
    clk_can = 1'b0;
    forever #5 clk_can = ~clk_can;
  end

  initial begin
    forever begin
      @(posedge clk_can);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] make_exp(input logic err, input logic [1:0] idx,
                                            input logic [5:0] addr, input logic [63:0] data);
    return {err, idx, addr, data};
  endfunction

  task automatic set_mb(input int k, input logic [63:0] d, input logic [5:0] a);
    mb_data_i[64*k +: 64] = d;
    mb_addr_i[6*k +: 6]   = a;
  endtask

  task automatic wait_rises(input int target, input string tag);
    int i = 0;
    while (n_rises < target && i < 600) begin
      @(negedge clk_can);
      i++;
    end
    check(tag, n_rises >= target, 1'b1);
  endtask

  task automatic wait_quiet(input string tag);
    int i = 0;
    while ((exp_q.size() != 0 || busy_o) && i < 4000) begin
      @(negedge clk_can);
      i++;
    end
    repeat (2) @(negedge clk_can);
    check(tag, exp_q.size(), 0);
  endtask

  // can_tx model: reacts to tx_start_o with the next scripted response.
  initial begin : can_model
    int code;
    int len;
    int i;
    tx_busy_i    = 1'b0;
    frame_sent_i = 1'b0;
    ack_i        = 1'b0;
    lost_arb_i   = 1'b0;
    forever begin
      @(negedge clk_can);
      if (tx_start_o && rst_i) begin
        n_starts++;
        code = (resp_q.size() > 0) ? resp_q.pop_front() : R_ACK;
        if (code == R_NOBUSY) begin
          len = 1;
          while (tx_start_o && len < 100) begin
            @(negedge clk_can);
            if (tx_start_o) len++;
          end
          check("start_timeout_len", len, START_TO);
        end else begin
          repeat (2) @(negedge clk_can);
          tx_busy_i = 1'b1;
          if (code == R_HOLD) begin
            i = 0;
            while (tx_start_o && i < 400) begin
              @(negedge clk_can);
              i++;
            end
          end else begin
            repeat (3) @(negedge clk_can);
            if (code == R_LOST) begin
              lost_arb_i = 1'b1;
            end else begin
              frame_sent_i = 1'b1;
              ack_i        = (code == R_ACK);
            end
            @(negedge clk_can);
            lost_arb_i   = 1'b0;
            frame_sent_i = 1'b0;
            ack_i        = 1'b0;
          end
          tx_busy_i = 1'b0;
        end
      end
    end
  end

  // Scoreboard and timing monitor: checks result pulses against exp_q, the
  // pulse shape, and the recessive gap before each tx_start rise. The
  // requester drops its request on its own result pulse.
  initial begin : monitor
    logic          prev_pulse;
    logic          prev_start;
    int            low_run;
    logic [N_MB-1:0] pulse;
    logic [1:0]    idx;
    logic [W-1:0]  obs;
    logic [W-1:0]  e;
    prev_pulse = 1'b0;
    prev_start = 1'b0;
    low_run    = 0;
    forever begin
      @(negedge clk_can);
      if (!rst_i) begin
        prev_pulse = 1'b0;
        prev_start = 1'b0;
        low_run    = 0;
      end else begin
        pulse = mb_done_o | mb_err_o;
        if (|pulse) begin
          check("pulse_onehot", $countones(pulse), 1);
          check("pulse_spacing", prev_pulse, 1'b0);
          idx = '0;
          for (int i = 0; i < N_MB; i++) if (pulse[i]) idx = 2'(i);
          obs = {|mb_err_o, idx, tx_remote_addr_o, tx_data_o};
          check("sb_pending", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_result", obs, e);
          end
          mb_req_i[idx] = 1'b0;
          n_pulses++;
          pulse_cyc = cyc;
        end
        prev_pulse = |pulse;
        if (tx_start_o && !prev_start) begin
          n_rises++;
          rise_cyc = cyc;
          check("gap_before_start", low_run >= IFS_BITS, 1'b1);
        end
        if (busy_o && !tx_start_o) low_run++;
        else low_run = 0;
        prev_start = tx_start_o;
      end
    end
  end

  // Directed sequence
  initial begin : main
    int base;
    int base_s;
    int ref_cyc;
    int i;
    rst_i     = 1'b0;
    mb_req_i  = '0;
    mb_data_i = '0;
    mb_addr_i = '0;
    rx_i      = 1'b1;
    repeat (3) @(negedge clk_can);

    check("rst_tx_start", tx_start_o, 1'b0);
    check("rst_tx_data", tx_data_o, 64'h0);
    check("rst_tx_addr", tx_remote_addr_o, 6'h0);
    check("rst_done_err", {mb_done_o, mb_err_o}, 8'h0);
    check("rst_busy_cur", {busy_o, cur_mb_o}, 3'h0);
    check("rst_lost_cnt", lost_arb_cnt_o, 8'h0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_can);

    // Single mailbox, latency and data latch
    set_mb(2, 64'hDEADBEEF_01234567, 6'h22);
    resp_q.push_back(R_ACK);
    exp_q.push_back(make_exp(1'b0, 2'd2, 6'h22, 64'hDEADBEEF_01234567));
    base    = n_rises;
    ref_cyc = cyc;
    mb_req_i = 4'b0100;
    wait_rises(base + 1, "t1_start_seen");
    check("t1_latency", rise_cyc - ref_cyc, 1 + IFS_BITS);
    check("t1_data", tx_data_o, 64'hDEADBEEF_01234567);
    check("t1_addr", tx_remote_addr_o, 6'h22);
    check("t1_cur_mb", cur_mb_o, 2'd2);
    check("t1_busy", busy_o, 1'b1);
    set_mb(2, 64'h1111_2222_3333_4444, 6'h05);
    @(negedge clk_can);
    check("t1_data_hold", tx_data_o, 64'hDEADBEEF_01234567);
    wait_quiet("t1_drained");

    // Priority 1 before 3; mailbox 0 raised mid-frame does not preempt
    set_mb(0, 64'hA0A0_0000_0000_00A0, 6'h10);
    set_mb(1, 64'hB1B1_1111_1111_11B1, 6'h11);
    set_mb(3, 64'hC3C3_3333_3333_33C3, 6'h13);
    repeat (3) resp_q.push_back(R_ACK);
    exp_q.push_back(make_exp(1'b0, 2'd1, 6'h11, 64'hB1B1_1111_1111_11B1));
    exp_q.push_back(make_exp(1'b0, 2'd3, 6'h13, 64'hC3C3_3333_3333_33C3));
    base = n_rises;
    mb_req_i = 4'b1010;
    wait_rises(base + 1, "t2_first_start");
    check("t2_first_cur", cur_mb_o, 2'd1);
    check("t2_first_data", tx_data_o, 64'hB1B1_1111_1111_11B1);
    wait_rises(base + 2, "t2_second_start");
    check("t2_second_latency", rise_cyc - pulse_cyc, 1 + IFS_BITS);
    check("t2_second_cur", cur_mb_o, 2'd3);
    exp_q.push_back(make_exp(1'b0, 2'd0, 6'h10, 64'hA0A0_0000_0000_00A0));
    mb_req_i[0] = 1'b1;
    repeat (2) @(negedge clk_can);
    check("t2_no_preempt_cur", cur_mb_o, 2'd3);
    check("t2_no_preempt_data", tx_data_o, 64'hC3C3_3333_3333_33C3);
    check("t2_no_preempt_start", tx_start_o, 1'b1);
    wait_quiet("t2_drained");

    // Gap restart: rx low while gap_cnt is 7
    set_mb(0, 64'h0123_4567_89AB_CDEF, 6'h3F);
    resp_q.push_back(R_ACK);
    exp_q.push_back(make_exp(1'b0, 2'd0, 6'h3F, 64'h0123_4567_89AB_CDEF));
    base = n_rises;
    mb_req_i[0] = 1'b1;
    repeat (8) @(negedge clk_can);
    rx_i = 1'b0;
    @(negedge clk_can);
    rx_i    = 1'b1;
    ref_cyc = cyc;
    check("t3_no_early_start", n_rises - base, 0);
    wait_rises(base + 1, "t3_start_seen");
    check("t3_restart_len", rise_cyc - ref_cyc, IFS_BITS);
    wait_quiet("t3_drained");

    // Three lost arbitrations, then success
    set_mb(2, 64'hFEED_FACE_CAFE_BABE, 6'h2A);
    repeat (3) resp_q.push_back(R_LOST);
    resp_q.push_back(R_ACK);
    exp_q.push_back(make_exp(1'b0, 2'd2, 6'h2A, 64'hFEED_FACE_CAFE_BABE));
    base_s = n_starts;
    mb_req_i[2] = 1'b1;
    wait_quiet("t4_drained");
    check("t4_lost_cnt", lost_arb_cnt_o, 8'd3);
    check("t4_attempts", n_starts - base_s, 4);

    // Retry exhaustion: every frame unacknowledged
    set_mb(1, {$urandom(), $urandom()}, 6'($urandom_range(0, 63)));
    repeat (RETRY_MAX) resp_q.push_back(R_NACK);
    exp_q.push_back(make_exp(1'b1, 2'd1, mb_addr_i[6 +: 6], mb_data_i[64 +: 64]));
    base_s = n_starts;
    mb_req_i[1] = 1'b1;
    wait_quiet("t5_drained");
    repeat (20) @(negedge clk_can);
    check("t5_attempts", n_starts - base_s, RETRY_MAX);
    check("t5_lost_cnt", lost_arb_cnt_o, 8'd3);

    // Retry exhaustion: tx_busy never rises
    set_mb(3, {$urandom(), $urandom()}, 6'($urandom_range(0, 63)));
    repeat (RETRY_MAX) resp_q.push_back(R_NOBUSY);
    exp_q.push_back(make_exp(1'b1, 2'd3, mb_addr_i[18 +: 6], mb_data_i[192 +: 64]));
    base_s = n_starts;
    mb_req_i[3] = 1'b1;
    wait_quiet("t5b_drained");
    check("t5b_attempts", n_starts - base_s, RETRY_MAX);

    // Abort in GAP: error pulse and no start
    set_mb(0, 64'h5555_AAAA_5555_AAAA, 6'h01);
    base = n_rises;
    mb_req_i[0] = 1'b1;
    repeat (5) @(negedge clk_can);
    exp_q.push_back(make_exp(1'b1, 2'd0, 6'h01, 64'h5555_AAAA_5555_AAAA));
    mb_req_i[0] = 1'b0;
    wait_quiet("t6_drained");
    repeat (15) @(negedge clk_can);
    check("t6_no_start", n_rises - base, 0);

    // Asynchronous reset during WAIT_DONE
    set_mb(2, 64'h7777_8888_9999_0000, 6'h33);
    resp_q.push_back(R_HOLD);
    base = n_rises;
    mb_req_i[2] = 1'b1;
    wait_rises(base + 1, "t7_start_seen");
    i = 0;
    while (!tx_busy_i && i < 50) begin
      @(negedge clk_can);
      i++;
    end
    repeat (2) @(negedge clk_can);
    check("t7_in_frame", {busy_o, tx_start_o}, 2'b11);
    #2 rst_i = 1'b0;
    #1;
    check("t7_async_start", tx_start_o, 1'b0);
    check("t7_rst_data", tx_data_o, 64'h0);
    check("t7_rst_addr", tx_remote_addr_o, 6'h0);
    check("t7_rst_busy_cur", {busy_o, cur_mb_o}, 3'h0);
    check("t7_rst_lost_cnt", lost_arb_cnt_o, 8'h0);
    check("t7_rst_pulses", {mb_done_o, mb_err_o}, 8'h0);
    mb_req_i = '0;
    @(negedge clk_can);
    rst_i = 1'b1;
    repeat (5) @(negedge clk_can);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Transmit-side controller for the CAN core: shares the single can_tx frame engine between N_MB mailbox requesters.
- Selects a mailbox by fixed priority, enforces the interframe gap, and drives the engine's start level and frame fields.
- Retries on lost arbitration or missing ACK, and reports done/error per mailbox.
- Runs entirely in the CAN bit-clock domain, between the host/DMA-side mailboxes and can_tx.

Parameters:
N_MB, 4, number of mailbox requesters; index 0 = highest priority
IFS_BITS, 11, consecutive recessive bus bits required before any start
RETRY_MAX, 8, failed attempts allowed before error; attempt count width = clog2(RETRY_MAX+1)
START_TO, 16, clk_can cycles allowed for tx_busy_i to rise after tx_start_o

Ports:
clk_can  in  1  CAN bit clock
rst_i  in  1  asynchronous reset, active-low
mb_req_i  in  N_MB  per-mailbox transmit request (level)
mb_data_i  in  64*N_MB  payload; mailbox k occupies [64k+63:64k]
mb_addr_i  in  6*N_MB  remote address; mailbox k occupies [6k+5:6k]
mb_done_o  out  N_MB  one-cycle pulse: frame sent and acknowledged
mb_err_o  out  N_MB  one-cycle pulse: RETRY_MAX exhausted or mailbox aborted
rx_i  in  1  bus level (1 = recessive)
tx_start_o  out  1  start level to can_tx
tx_data_o  out  64  payload to can_tx
tx_remote_addr_o  out  6  remote address to can_tx
tx_busy_i  in  1  can_tx busy
frame_sent_i  in  1  can_tx frame-complete pulse
ack_i  in  1  can_tx acknowledged flag; valid with frame_sent_i
lost_arb_i  in  1  can_tx lost-arbitration pulse
busy_o  out  1  high in every state except IDLE
cur_mb_o  out  clog2(N_MB)  index of the selected mailbox
lost_arb_cnt_o  out  8  saturating count of lost arbitrations since reset

Behaviour:
- Reset (async, rst_i=0):
  - State goes to IDLE.
  - All outputs are 0, including the tx_data_o and tx_remote_addr_o registers.
  - The attempt counter, gap counter, timeout counter and mask register are cleared.
  - Reset mid-frame drops tx_start_o immediately.
- IDLE:
  - If any (mb_req_i & ~mask) bit is set, the lowest such index k is selected.
  - Payload and address of mailbox k are latched into tx_data_o and tx_remote_addr_o.
  - cur_mb_o<=k, attempt counter<=0, go to GAP.
  - The mask register clears every cycle spent in IDLE.
- GAP:
  - gap_cnt increments while rx_i=1 and clears to 0 on any rx_i=0.
  - When gap_cnt reaches IFS_BITS, set tx_start_o=1 and go to START.
  - If mb_req_i[k] drops while in GAP: pulse mb_err_o[k], go to IDLE, no frame started.
- START:
  - tx_start_o held at 1.
  - tx_busy_i=1 -> go to WAIT_DONE.
  - START_TO cycles with no tx_busy_i -> failed attempt.
- WAIT_DONE:
  - tx_start_o held at 1 until the result.
  - frame_sent_i=1 with ack_i=1 -> success.
  - frame_sent_i=1 with ack_i=0 -> failed attempt.
  - lost_arb_i=1 -> failed attempt; lost_arb_cnt_o increments, saturating at 255.
  - lost_arb_i and frame_sent_i in the same cycle -> treated as lost arbitration.
- Success:
  - tx_start_o<=0, pulse mb_done_o[k] for 1 cycle.
  - mask[k]<=1, so the requester has one cycle to drop mb_req_i[k].
  - Go to IDLE.
- Failed attempt:
  - tx_start_o<=0, attempt counter increments.
  - If the counter equals RETRY_MAX: pulse mb_err_o[k], set mask[k], go to IDLE.
  - Else if mb_req_i[k] is still 1: go to GAP with gap_cnt=0 and latched data unchanged; no re-arbitration and no preemption.
  - Else: pulse mb_err_o[k] and go to IDLE.
- Requester dropping mb_req_i[k] during START/WAIT_DONE: the attempt completes; success is reported normally, failure is reported as error without retry.
- Data hold: mb_data_i and mb_addr_i are sampled only in IDLE; later changes have no effect until the next selection.
- Latency:
  - Request high in IDLE -> tx_start_o=1 no earlier than 1+IFS_BITS cycles (IDLE->GAP, then IFS_BITS recessive cycles).
  - Result pulse occurs 1 cycle after frame_sent_i or lost_arb_i.
- Pulse shape: at most one bit of mb_done_o|mb_err_o is high in any cycle, and never for two consecutive cycles.

Test Plan:
- Single mailbox: mb_req_i=4'b0100, data 64'hDEADBEEF_01234567, addr 6'h22, rx_i=1 throughout; can_tx model gives busy then frame_sent with ack=1.
  - tx_start_o rises 12 cycles after the request.
  - tx_data_o and tx_remote_addr_o match the request.
  - mb_done_o=4'b0100 for exactly 1 cycle.
- Priority: mb_req_i=4'b1010 simultaneously.
  - Mailbox 1 is served first (cur_mb_o=1).
  - Mailbox 3 is served after mask release; no preemption when mailbox 0 is raised mid-frame.
- Gap: rx_i pulled low at gap_cnt=7.
  - Counter restarts; tx_start_o rises only after 11 further consecutive recessive cycles.
- Lost arbitration: lost_arb_i pulsed 3 times, then success.
  - lost_arb_cnt_o=3, single mb_done_o pulse, tx_start_o low for at least IFS_BITS cycles between attempts.
- Retry exhaustion: RETRY_MAX=8, every frame_sent_i arrives with ack_i=0; separately, tx_busy_i never rises.
  - mb_err_o pulses after the 8th failure.
  - The no-busy case times out after 16 cycles per attempt.
- Abort and reset: mb_req_i dropped in GAP -> mb_err_o pulse, no tx_start_o.
  - rst_i=0 during WAIT_DONE -> tx_start_o=0 asynchronously and all outputs return to 0.
